// File: rtl/state_ntt_polyadd.sv
// state_ntt_polyadd
//   Sweeps two 256-coefficient polynomials (RAM A and RAM B, synchronous read)
//   and writes the coefficient-wise sum r[i] = a[i] + b[i] to a destination RAM.
//   Start/done handshake matches the other NTT state blocks.
//
// Optional build macro: POLYADD_CSUBQ_EN
//   When defined, an extra pipeline stage reduces the sum into [0, KYBER_Q)
//   with one conditional subtract. Write latency becomes 3 cycles and the
//   drain phase lasts 3 cycles. When undefined, the result is the plain
//   16-bit wrapping sum with a 2-cycle write latency.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         start request, sampled in IDLE
//   PolyA_RData    RAM A read data, valid one cycle after address
//   PolyB_RData    RAM B read data, valid one cycle after address
//   Coef_RAd       shared read address to RAM A and RAM B
//   Coef_WEN       destination write enable
//   Coef_WAd       destination write address
//   Coef_WData     destination write data
//   Poly_Add_busy  high from start until the done pulse inclusive
//   Poly_Add_done  one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for enable
// READ  | issuing read addresses 0..KYBER_N-1
// DRAIN | flushing the read/add pipeline
// DONE  | completion pulse, then back to IDLE

module state_ntt_polyadd #(
  parameter int KYBER_K = 2,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] PolyA_RData,
  input  logic [15:0] PolyB_RData,
  output logic [7:0]  Coef_RAd,
  output logic        Coef_WEN,
  output logic [7:0]  Coef_WAd,
  output logic [15:0] Coef_WData,
  output logic        Poly_Add_busy,
  output logic        Poly_Add_done
);

  localparam int AW = 8;
  localparam int CW = AW + 1;
`ifdef POLYADD_CSUBQ_EN
  localparam int DRAIN_CYC = 3;
`else
  localparam int DRAIN_CYC = 2;
`endif

  // Elaboration-time range guards; the blocks are intentionally empty.
  if (KYBER_K < 1) begin : g_k_out_of_range
  end
  if (KYBER_N != 256) begin : g_n_not_256
  end
  if (KYBER_Q >= 65536) begin : g_q_too_wide
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] rad_nxt;
  logic          busy_nxt, done_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      Coef_RAd      <= '0;
      Poly_Add_busy <= 1'b0;
      Poly_Add_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      Coef_RAd      <= rad_nxt;
      Poly_Add_busy <= busy_nxt;
      Poly_Add_done <= done_nxt;
    end
  end

  // cnt holds the next address to issue while in READ, and the elapsed
  // drain cycles while in DRAIN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rad_nxt   = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = READ;
          cnt_nxt   = CW'(1);
          busy_nxt  = 1'b1;
        end
      end
      READ: begin
        busy_nxt = 1'b1;
        if (cnt == CW'(KYBER_N)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          rad_nxt = cnt[AW-1:0];
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        busy_nxt = 1'b1;
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Read pipeline: address issued in READ returns data one cycle later.
  logic          rd_vld;
  logic [AW-1:0] rd_addr;
  logic [15:0]   sum;

  assign sum = PolyA_RData + PolyB_RData;

`ifdef POLYADD_CSUBQ_EN
  logic          s_vld;
  logic [AW-1:0] s_addr;
  logic [15:0]   s_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld     <= 1'b0;
      rd_addr    <= '0;
      s_vld      <= 1'b0;
      s_addr     <= '0;
      s_reg      <= '0;
      Coef_WEN   <= 1'b0;
      Coef_WAd   <= '0;
      Coef_WData <= '0;
    end else begin
      rd_vld     <= (state == READ);
      rd_addr    <= Coef_RAd;
      s_vld      <= rd_vld;
      s_addr     <= rd_addr;
      s_reg      <= sum;
      Coef_WEN   <= s_vld;
      Coef_WAd   <= s_addr;
      // Operands are in [0, Q), so one subtract lands the sum in [0, Q).
      Coef_WData <= (s_reg >= 16'(KYBER_Q)) ? (s_reg - 16'(KYBER_Q)) : s_reg;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld     <= 1'b0;
      rd_addr    <= '0;
      Coef_WEN   <= 1'b0;
      Coef_WAd   <= '0;
      Coef_WData <= '0;
    end else begin
      rd_vld     <= (state == READ);
      rd_addr    <= Coef_RAd;
      Coef_WEN   <= rd_vld;
      Coef_WAd   <= rd_addr;
      Coef_WData <= sum;
    end
  end
`endif

endmodule
